// File: rtl/kb_pkg.sv
// Shared scan-code constants, direction encoding and FSM state type for the
// keyboard move decoder.
package kb_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_UP    = 8'h75;
    localparam logic [7:0] PS2_DOWN  = 8'h72;
    localparam logic [7:0] PS2_LEFT  = 8'h6B;
    localparam logic [7:0] PS2_RIGHT = 8'h74;
    localparam logic [7:0] PS2_W     = 8'h1D;
    localparam logic [7:0] PS2_S     = 8'h1B;
    localparam logic [7:0] PS2_A     = 8'h1C;
    localparam logic [7:0] PS2_D     = 8'h23;
    localparam logic [7:0] PS2_SPACE = 8'h29;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } kb_state_t;

endpackage

// File: rtl/kb_dir_lut.sv
// Combinational scan-code to direction lookup; the only place the key map lives.
module kb_dir_lut
    import kb_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    input  logic       accept_wasd,
    output logic       hit,
    output logic [1:0] dir
);

    always_comb begin
        hit = 1'b0;
        dir = DIR_UP;
        if (ext) begin
            case (code)
                PS2_UP:    begin hit = 1'b1; dir = DIR_UP;    end
                PS2_DOWN:  begin hit = 1'b1; dir = DIR_DOWN;  end
                PS2_LEFT:  begin hit = 1'b1; dir = DIR_LEFT;  end
                PS2_RIGHT: begin hit = 1'b1; dir = DIR_RIGHT; end
                default:   ;
            endcase
        end else if (accept_wasd) begin
            case (code)
                PS2_W:   begin hit = 1'b1; dir = DIR_UP;    end
                PS2_S:   begin hit = 1'b1; dir = DIR_DOWN;  end
                PS2_A:   begin hit = 1'b1; dir = DIR_LEFT;  end
                PS2_D:   begin hit = 1'b1; dir = DIR_RIGHT; end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/kb_move_decoder.sv
// PS/2 set-2 scan-code FIFO drain producing maze move pulses, held mask and regen tick.
// Optional KB_REPEAT_FILTER_EN: suppress move pulses for typematic repeats of held keys.
module kb_move_decoder
    import kb_pkg::*;
#(
    parameter bit ACCEPT_WASD = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] key_code,
    input  logic       kb_buf_empty,
    output logic       rd_key_code,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic [3:0] held,
    output logic       regen_tick
);

    kb_state_t  state_reg, state_next;
    logic [3:0] held_reg, held_next;
    logic       move_valid_reg, move_valid_next;
    logic [1:0] move_dir_reg, move_dir_next;
    logic       regen_tick_reg, regen_tick_next;

    logic       pop;
    logic       lut_ext;
    logic       lut_hit;
    logic [1:0] lut_dir;
    logic       is_make;
    logic       is_break;

    // Never back-pressures: every available byte is popped and decoded this cycle.
    assign rd_key_code = ~kb_buf_empty & ~reset;
    assign pop         = rd_key_code;
    assign lut_ext     = (state_reg == S_EXT) || (state_reg == S_EXT_BRK);

    kb_dir_lut u_lut (
        .code        (key_code),
        .ext         (lut_ext),
        .accept_wasd (ACCEPT_WASD),
        .hit         (lut_hit),
        .dir         (lut_dir)
    );

    always_comb begin
        state_next      = state_reg;
        held_next       = held_reg;
        move_valid_next = 1'b0;
        move_dir_next   = move_dir_reg;
        regen_tick_next = 1'b0;
        is_make         = 1'b0;
        is_break        = 1'b0;

        if (pop) begin
            case (state_reg)
                S_IDLE: begin
                    if (key_code == PS2_EXT) begin
                        state_next = S_EXT;
                    end else if (key_code == PS2_BRK) begin
                        state_next = S_BRK;
                    end else begin
                        is_make = 1'b1;
                        if (key_code == PS2_SPACE) begin
                            regen_tick_next = 1'b1;
                        end
                    end
                end
                S_EXT: begin
                    if (key_code == PS2_BRK) begin
                        state_next = S_EXT_BRK;
                    end else if (key_code != PS2_EXT) begin
                        is_make    = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (key_code != PS2_BRK) begin
                        is_break   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                S_EXT_BRK: begin
                    if ((key_code != PS2_BRK) && (key_code != PS2_EXT)) begin
                        is_break   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end

        if (is_make && lut_hit) begin
            held_next[lut_dir] = 1'b1;
`ifdef KB_REPEAT_FILTER_EN
            if (!held_reg[lut_dir]) begin
                move_valid_next = 1'b1;
                move_dir_next   = lut_dir;
            end
`else
            move_valid_next = 1'b1;
            move_dir_next   = lut_dir;
`endif
        end

        if (is_break && lut_hit) begin
            held_next[lut_dir] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            held_reg       <= 4'b0000;
            move_valid_reg <= 1'b0;
            move_dir_reg   <= 2'd0;
            regen_tick_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            held_reg       <= held_next;
            move_valid_reg <= move_valid_next;
            move_dir_reg   <= move_dir_next;
            regen_tick_reg <= regen_tick_next;
        end
    end

    assign move_valid = move_valid_reg;
    assign move_dir   = move_dir_reg;
    assign held       = held_reg;
    assign regen_tick = regen_tick_reg;

endmodule

// File: tb/tb_kb_move_decoder.sv
// Scoreboard bench for kb_move_decoder: a WASD-enabled and an arrows-only
// instance share one byte stream; a negedge monitor checks every pulse.
module tb_kb_move_decoder;

`ifdef KB_REPEAT_FILTER_EN
    localparam bit RPT_FILTER = 1'b1;
`else
    localparam bit RPT_FILTER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] key_code;
    logic       kb_buf_empty;

    logic       rd_w, mv_w, rg_w;
    logic [1:0] dir_w;
    logic [3:0] held_w;
    logic       rd_n, mv_n, rg_n;
    logic [1:0] dir_n;
    logic [3:0] held_n;

    int tests = 0;
    int fails = 0;

    logic [1:0] q_w[$];
    logic [1:0] q_n[$];
    int         q_rg_w[$];
    int         q_rg_n[$];
    logic [1:0] e_w, e_n;
    int         e_rg;

    kb_move_decoder #(.ACCEPT_WASD(1'b1)) dut_w (
        .clk(clk), .reset(reset), .key_code(key_code), .kb_buf_empty(kb_buf_empty),
        .rd_key_code(rd_w), .move_valid(mv_w), .move_dir(dir_w), .held(held_w),
        .regen_tick(rg_w)
    );

    kb_move_decoder #(.ACCEPT_WASD(1'b0)) dut_n (
        .clk(clk), .reset(reset), .key_code(key_code), .kb_buf_empty(kb_buf_empty),
        .rd_key_code(rd_n), .move_valid(mv_n), .move_dir(dir_n), .held(held_n),
        .regen_tick(rg_n)
    );

    always #5 clk = ~clk;

    // Monitor: every presented pulse must match the head of its expectation queue.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (mv_w === 1'b1) begin
                tests++;
                if (q_w.size() == 0) begin
                    fails++;
                    $display("FAIL move_w: unexpected pulse dir=%0d, required no pulse", dir_w);
                end else begin
                    e_w = q_w.pop_front();
                    if (dir_w !== e_w) begin
                        fails++;
                        $display("FAIL move_w_dir: got %0d, required %0d", dir_w, e_w);
                    end else
                        $display("[TB] wasd dut move dir=%0d ok", dir_w);
                end
            end
            if (mv_n === 1'b1) begin
                tests++;
                if (q_n.size() == 0) begin
                    fails++;
                    $display("FAIL move_n: unexpected pulse dir=%0d, required no pulse", dir_n);
                end else begin
                    e_n = q_n.pop_front();
                    if (dir_n !== e_n) begin
                        fails++;
                        $display("FAIL move_n_dir: got %0d, required %0d", dir_n, e_n);
                    end else
                        $display("[TB] arrow dut move dir=%0d ok", dir_n);
                end
            end
            if (rg_w === 1'b1) begin
                tests++;
                if (q_rg_w.size() == 0) begin
                    fails++;
                    $display("FAIL regen_w: unexpected regen_tick, required none");
                end else begin
                    e_rg = q_rg_w.pop_front();
                    $display("[TB] wasd dut regen_tick ok");
                end
            end
            if (rg_n === 1'b1) begin
                tests++;
                if (q_rg_n.size() == 0) begin
                    fails++;
                    $display("FAIL regen_n: unexpected regen_tick, required none");
                end else begin
                    e_rg = q_rg_n.pop_front();
                    $display("[TB] arrow dut regen_tick ok");
                end
            end
        end
    end

    // Present one byte for one cycle; called at a negedge, returns at the next negedge.
    task automatic send(input logic [7:0] b);
        key_code     = b;
        kb_buf_empty = 1'b0;
        #1;
        tests++;
        if (rd_w !== 1'b1 || rd_n !== 1'b1) begin
            fails++;
            $display("FAIL rd_pop: byte %h rd_w=%b rd_n=%b, required 1", b, rd_w, rd_n);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        kb_buf_empty = 1'b1;
        #1;
        tests++;
        if (rd_w !== 1'b0 || rd_n !== 1'b0) begin
            fails++;
            $display("FAIL rd_empty: rd_w=%b rd_n=%b, required 0", rd_w, rd_n);
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_move(input logic [1:0] d, input bit both);
        q_w.push_back(d);
        if (both) q_n.push_back(d);
    endtask

    task automatic check_held(input string name, input logic [3:0] hw, input logic [3:0] hn);
        tests++;
        if (held_w !== hw || held_n !== hn) begin
            fails++;
            $display("FAIL held_%s: got w=%b n=%b, required w=%b n=%b",
                     name, held_w, held_n, hw, hn);
        end else
            $display("[TB] held_%s w=%b n=%b ok", name, held_w, held_n);
    endtask

    // Every queued expectation must have been consumed by the monitor.
    task automatic check_drain(input string name);
        tests++;
        if (q_w.size() != 0 || q_n.size() != 0 || q_rg_w.size() != 0 || q_rg_n.size() != 0) begin
            fails++;
            $display("FAIL drain_%s: pending w=%0d n=%0d rg_w=%0d rg_n=%0d, required all 0",
                     name, q_w.size(), q_n.size(), q_rg_w.size(), q_rg_n.size());
        end
        q_w.delete(); q_n.delete(); q_rg_w.delete(); q_rg_n.delete();
    endtask

    initial begin
        reset        = 1'b1;
        key_code     = 8'h00;
        kb_buf_empty = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (mv_w !== 1'b0 || dir_w !== 2'd0 || held_w !== 4'd0 || rg_w !== 1'b0 ||
            mv_n !== 1'b0 || held_n !== 4'd0 || rg_n !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: mv=%b dir=%0d held=%b rg=%b, required 0 0 0000 0",
                     mv_w, dir_w, held_w, rg_w);
        end
        reset = 1'b0;
        @(negedge clk);

        // Extended up make, then its break
        send(8'hE0); expect_move(2'd0, 1'b1); send(8'h75); idle(2);
        check_held("up_make", 4'b0001, 4'b0001);
        send(8'hE0); send(8'hF0); send(8'h75); idle(2);
        check_held("up_break", 4'b0000, 4'b0000);
        check_drain("up");

        // Right make then break: one pulse only
        send(8'hE0); expect_move(2'd3, 1'b1); send(8'h74); idle(2);
        check_held("right_make", 4'b1000, 4'b1000);
        send(8'hE0); send(8'hF0); send(8'h74); idle(2);
        check_held("right_break", 4'b0000, 4'b0000);
        check_drain("right");

        // WASD: A left only on the WASD instance; W shares the up bit with the arrow
        expect_move(2'd2, 1'b0); send(8'h1C); idle(2);
        check_held("a_make", 4'b0100, 4'b0000);
        send(8'hF0); send(8'h1C); idle(1);
        check_held("a_break", 4'b0000, 4'b0000);
        expect_move(2'd0, 1'b0); send(8'h1D); idle(1);
        check_held("w_make", 4'b0001, 4'b0000);
        send(8'hE0); send(8'hF0); send(8'h75); idle(1);
        check_held("w_arrow_release", 4'b0000, 4'b0000);
        // Back-to-back makes in consecutive cycles
        expect_move(2'd0, 1'b0); send(8'h1D);
        expect_move(2'd3, 1'b0); send(8'h23);
        expect_move(2'd1, 1'b0); send(8'h1B); idle(2);
        check_held("b2b", 4'b1011, 4'b0000);
        send(8'hF0); send(8'h1D); send(8'hF0); send(8'h23); send(8'hF0); send(8'h1B); idle(2);
        check_held("b2b_release", 4'b0000, 4'b0000);
        check_drain("wasd");

        // Typematic down repeats
        for (int i = 0; i < 3; i++) begin
            send(8'hE0);
            if (!RPT_FILTER || i == 0) expect_move(2'd1, 1'b1);
            send(8'h72);
        end
        idle(2);
        check_held("typematic", 4'b0010, 4'b0010);
        send(8'hE0); send(8'hF0); send(8'h72); idle(2);
        check_held("typematic_rel", 4'b0000, 4'b0000);
        check_drain("typematic");

        // Space make ticks once; break and unmapped bytes are silent
        q_rg_w.push_back(1); q_rg_n.push_back(1);
        send(8'h29); send(8'hF0); send(8'h29);
        send(8'hFA); send(8'hAA); send(8'hE0); send(8'h29);
        send(8'hE0); send(8'h1C); idle(2);
        check_held("unmapped", 4'b0000, 4'b0000);
        // A following extended left proves the FSM is back in S_IDLE
        send(8'hE0); expect_move(2'd2, 1'b1); send(8'h6B); idle(2);
        check_held("left_make", 4'b0100, 4'b0100);
        send(8'hE0); send(8'hF0); send(8'h6B); idle(2);
        check_drain("space");

        // Repeated prefixes are absorbed; FIFO empty mid-sequence holds state
        send(8'hE0); send(8'hE0); idle(5);
        expect_move(2'd0, 1'b1); send(8'h75); idle(2);
        check_held("ext_hold", 4'b0001, 4'b0001);
        send(8'hE0); send(8'hF0); idle(3); send(8'hE0); send(8'hF0); send(8'h75); idle(2);
        check_held("ext_brk_hold", 4'b0000, 4'b0000);
        check_drain("prefix");

        // Reset mid-sequence drops the E0 prefix and clears held
        send(8'hE0); expect_move(2'd3, 1'b1); send(8'h74);
        send(8'hE0);
        reset = 1'b1; key_code = 8'h75; kb_buf_empty = 1'b0;
        #1;
        tests++;
        if (rd_w !== 1'b0 || rd_n !== 1'b0) begin
            fails++;
            $display("FAIL rd_reset: rd_w=%b rd_n=%b, required 0", rd_w, rd_n);
        end
        repeat (2) @(negedge clk);
        check_held("in_reset", 4'b0000, 4'b0000);
        reset = 1'b0;
        send(8'h75); idle(3);
        check_held("after_reset", 4'b0000, 4'b0000);
        check_drain("reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
